keypad_scanner: RTL and testbench

//   Scans a 4x4 active-low matrix keypad, the operator-input side of the parking console.
//   It drives one column low at a time and reads the row lines, the input-side mirror of the multiplexed 7-segment driver.

---
 rtl/smart_parking_pkg.sv | 34 +++
 rtl/keypad_scanner_if.sv | 13 +
 rtl/keypad_tick_gen.sv | 19 +
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/smart_parking_pkg.sv
// Shared types and constants for the parking console keypad front end.
package smart_parking_pkg;

  localparam int unsigned KP_ROWS   = 4;
  localparam int unsigned KP_COLS   = 4;
  localparam int unsigned KP_IDX_W  = 2;
  localparam int unsigned KP_CODE_W = 4;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_HELD     = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [KP_IDX_W-1:0] row;
    logic [KP_IDX_W-1:0] col;
  } key_code_t;

  localparam logic [KP_CODE_W-1:0] KEY_ENTER  = 4'hE;
  localparam logic [KP_CODE_W-1:0] KEY_CANCEL = 4'hF;

  // Index of the lowest-numbered row pulled low (0 when none are low).
  function automatic logic [KP_IDX_W-1:0] kp_first_low(input logic [KP_ROWS-1:0] rows);
    logic [KP_IDX_W-1:0] idx;
    idx = '0;
    for (int i = KP_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = KP_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the accepted-key output toward the slot control FSM.
interface keypad_scanner_if
  import smart_parking_pkg::*;
  ;
  logic [KP_ROWS-1:0] row_in;
  logic [KP_COLS-1:0] col_out;
  key_code_t          key_code;
  logic               key_valid;
  logic               key_held;

  modport master (input row_in, output col_out, key_code, key_valid, key_held);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running scan divider; tick_c is high for one clock each time it reads all-ones.
module keypad_tick_gen #(
  parameter int unsigned CLK_DIV_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_c
);

  logic [CLK_DIV_W-1:0] div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_q + CLK_DIV_W'(1);
  end

  assign tick_c = (div_q == '1);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and a one-clock key_valid pulse.
// Define KEYPAD_REPEAT_EN to build auto-repeat (adds the REPEAT_TICKS parameter).
module keypad_scanner
  import smart_parking_pkg::*;
#(
  parameter int unsigned CLK_DIV_W      = 16,
  parameter int unsigned DEBOUNCE_TICKS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_TICKS = 64
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
`endif

  logic                tick_c;
  logic [KP_ROWS-1:0]  sync1_q, sync2_q;
  kp_state_e           state_q, state_d;
  logic [KP_IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  key_code_t           key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic [KP_COLS-1:0]  col_out_q;
  logic                any_low_c;
  logic [KP_IDX_W-1:0] low_row_c;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0]    rep_q, rep_d;
`endif

  keypad_tick_gen #(.CLK_DIV_W(CLK_DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_c  (tick_c)
  );

  assign any_low_c = (sync2_q != '1);
  assign low_row_c = kp_first_low(sync2_q);

  // Rows are asynchronous to clk; only sync2_q is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kp.row_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= KP_SCAN;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_out_q   <= 4'b1110;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_out_q   <= ~(4'b0001 << col_d);
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // Next-state logic; nothing moves except on tick cycles.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (tick_c) begin
      unique case (state_q)
        KP_SCAN: begin
          if (any_low_c) begin
            row_d   = low_row_c;
            cnt_d   = CNT_W'(1);
            state_d = KP_DEBOUNCE;
          end else begin
            col_d = col_q + KP_IDX_W'(1);
          end
        end
        KP_DEBOUNCE: begin
          if (any_low_c && (low_row_c == row_q)) begin
            if ((cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_TICKS)) begin
              key_code_d  = '{row: row_q, col: col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = KP_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = KP_SCAN;
            col_d   = col_q + KP_IDX_W'(1);
          end
        end
        KP_HELD: begin
          if (!any_low_c) begin
            cnt_d   = CNT_W'(1);
            state_d = KP_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if ((rep_q + REP_W'(1)) == REP_W'(REPEAT_TICKS)) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
`endif
        end
        KP_RELEASE: begin
          if (!sync2_q[row_q]) begin
            state_d = KP_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (!any_low_c) begin
            if ((cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_TICKS)) begin
              key_held_d = 1'b0;
              state_d    = KP_SCAN;
              col_d      = col_q + KP_IDX_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = KP_SCAN;
      endcase
    end
  end

  assign kp.col_out   = col_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model; CLK_DIV_W=2 gives a tick every 4 clocks.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pressed = 16'h0;
  logic [3:0]  rows;
  logic [1:0]  tb_div;
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .CLK_DIV_W      (2),
    .DEBOUNCE_TICKS (4)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_TICKS (8)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
  end
  assign kp.row_in = rows;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_div <= 2'd0;
    else          tb_div <= tb_div + 2'd1;
  end

  always @(posedge clk) if (kp.key_valid) pulses <= pulses + 1;

  typedef struct {
    logic [15:0] pressed;
    logic [3:0]  col;
    logic        valid;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K41 = 16'h1010;
  localparam logic [15:0] K1  = 16'h0002;
  localparam logic [15:0] K0  = 16'h0001;

  vec_t vecs [31];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Return #1 after the clock edge at which the DUT consumed a tick.
  task automatic tick_edge();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tb_div != 2'd0 && n < 16);
    if (tb_div != 2'd0) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout got=%0d want=0", tb_div);
    end
  endtask

  task automatic chk_outs(input string nm, input int idx, input logic [3:0] col,
                          input logic valid, input logic held, input logic [3:0] code);
    chk({nm, "_col"},   idx, 16'(kp.col_out),   16'(col));
    chk({nm, "_valid"}, idx, 16'(kp.key_valid), 16'(valid));
    chk({nm, "_held"},  idx, 16'(kp.key_held),  16'(held));
    chk({nm, "_code"},  idx, 16'(kp.key_code),  16'(code));
  endtask

  initial begin
    int p0;
    vecs[0]  = '{16'h0, 4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{16'h0, 4'b1011, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{16'h0, 4'b0111, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{16'h0, 4'b1110, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{K9,    4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[5]  = '{K9,    4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[6]  = '{K9,    4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[7]  = '{K9,    4'b1101, 1'b0, 1'b0, 4'h0};
    vecs[8]  = '{K9,    4'b1101, 1'b1, 1'b1, 4'h9};
    vecs[9]  = '{K9,    4'b1101, 1'b0, 1'b1, 4'h9};
    vecs[10] = '{16'h0, 4'b1101, 1'b0, 1'b1, 4'h9};
    vecs[11] = '{16'h0, 4'b1101, 1'b0, 1'b1, 4'h9};
    vecs[12] = '{16'h0, 4'b1101, 1'b0, 1'b1, 4'h9};
    vecs[13] = '{16'h0, 4'b1011, 1'b0, 1'b0, 4'h9};
    vecs[14] = '{K3,    4'b0111, 1'b0, 1'b0, 4'h9};
    vecs[15] = '{K3,    4'b0111, 1'b0, 1'b0, 4'h9};
    vecs[16] = '{K3,    4'b0111, 1'b0, 1'b0, 4'h9};
    vecs[17] = '{16'h0, 4'b1110, 1'b0, 1'b0, 4'h9};
    vecs[18] = '{K41,   4'b1110, 1'b0, 1'b0, 4'h9};
    vecs[19] = '{K41,   4'b1110, 1'b0, 1'b0, 4'h9};
    vecs[20] = '{K41,   4'b1110, 1'b0, 1'b0, 4'h9};
    vecs[21] = '{K41,   4'b1110, 1'b1, 1'b1, 4'h4};
    vecs[22] = '{K41,   4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[23] = '{16'h0, 4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[24] = '{16'h0, 4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[25] = '{K41,   4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[26] = '{K41,   4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[27] = '{16'h0, 4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[28] = '{16'h0, 4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[29] = '{16'h0, 4'b1110, 1'b0, 1'b1, 4'h4};
    vecs[30] = '{16'h0, 4'b1101, 1'b0, 1'b0, 4'h4};

    #12;
    chk_outs("reset", 0, 4'b1110, 1'b0, 1'b0, 4'h0);
    #10 reset_n = 1'b1;

    // Scan cycle, clean press, bounce, dual-row press and release glitch.
    p0 = pulses;
    foreach (vecs[i]) begin
      pressed = vecs[i].pressed;
      tick_edge();
      chk_outs("vec", i, vecs[i].col, vecs[i].valid, vecs[i].held, vecs[i].code);
    end
    chk("table_pulses", 0, 16'(pulses - p0), 16'd2);

    // Reset during DEBOUNCE: outputs clear before any clock edge.
    p0 = pulses;
    pressed = K1;
    tick_edge();
    tick_edge();
    #2 reset_n = 1'b0;
    #1 chk_outs("mid_reset", 0, 4'b1110, 1'b0, 1'b0, 4'h0);
    pressed = 16'h0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick_edge();
    chk_outs("post_reset", 0, 4'b1101, 1'b0, 1'b0, 4'h0);
    chk("mid_reset_pulses", 0, 16'(pulses - p0), 16'd0);

    // Reset while the accept pulse is high: the pulse never reaches an edge.
    p0 = pulses;
    pressed = K9;
    for (int i = 0; i < 4; i++) tick_edge();
    chk_outs("pre_drop", 0, 4'b1101, 1'b1, 1'b1, 4'h9);
    #2 reset_n = 1'b0;
    #1 chk_outs("drop", 0, 4'b1110, 1'b0, 1'b0, 4'h0);
    pressed = 16'h0;
    @(posedge clk); #1;
    chk("drop_pulses", 0, 16'(pulses - p0), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: pulses at acceptance and every 8 held ticks after it.
    p0 = pulses;
    pressed = K0;
    for (int i = 0; i < 4; i++) tick_edge();
    chk_outs("rep_accept", 0, 4'b1110, 1'b1, 1'b1, 4'h0);
    for (int i = 1; i <= 20; i++) begin
      tick_edge();
      chk("rep_valid", i, 16'(kp.key_valid), 16'((i % 8) == 0));
    end
    pressed = 16'h0;
    for (int i = 0; i < 5; i++) tick_edge();
    chk("rep_pulses", 0, 16'(pulses - p0), 16'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
